// File: rtl/branch_facility_xl.sv
// Branch facility: owns CIA/NIA, CTR and LR, resolves I/B/XL-form branches,
// supports 32-bit mode truncation and a circular return-address stack.
module branch_facility_xl #(
  parameter int                ADDR_W     = 64,
  parameter int                RAS_DEPTH  = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_32b_mode,
  input  logic              i_stall,
  input  logic              i_en,
  input  logic [31:0]       i_instr,
  input  logic [1:0]        i_form,
  input  logic [31:0]       i_condition_register,
  input  logic [ADDR_W-1:0] i_target_address_register,
  input  logic              i_ctr_wr_en,
  input  logic [ADDR_W-1:0] i_ctr_wr_data,
  input  logic              i_lr_wr_en,
  input  logic [ADDR_W-1:0] i_lr_wr_data,
  output logic [ADDR_W-1:0] o_next_instr_addr,
  output logic [ADDR_W-1:0] o_current_instr_addr,
  output logic [ADDR_W-1:0] o_count_register,
  output logic [ADDR_W-1:0] o_link_register,
  output logic              o_taken,
  output logic              o_ras_mispredict,
  output logic              o_err
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] FORM_I  = 2'b00;
  localparam logic [1:0] FORM_B  = 2'b01;
  localparam logic [1:0] FORM_XL = 2'b10;

  localparam logic [9:0] XO_BCLR  = 10'd16;
  localparam logic [9:0] XO_BCCTR = 10'd528;
  localparam logic [9:0] XO_BCTAR = 10'd560;

  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_FOUR = ADDR_W'(4);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(RAS_DEPTH);

  // Architectural state
  logic [ADDR_W-1:0] cia_reg;
  logic [ADDR_W-1:0] ctr_reg;
  logic [ADDR_W-1:0] lr_reg;
  logic              boot_reg;
  logic              err_reg;
  logic              mispredict_reg;

  // Return-address stack
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ras_ptr_reg;
  logic [CNT_W-1:0]  ras_cnt_reg;
  logic [PTR_W-1:0]  ras_ptr_next;
  logic [CNT_W-1:0]  ras_cnt_next;
  logic [PTR_W-1:0]  ras_waddr;
  logic              ras_we;
  logic [ADDR_W-1:0] ras_top;

  // Instruction fields; instr bit 0 is the MSB, so field instr[k] is i_instr[31-k]
  logic [4:0]  bo;
  logic [4:0]  bi;
  logic [4:0]  cr_idx;
  logic [1:0]  bh;
  logic [9:0]  xo;
  logic        aa;
  logic        lk;
  logic        bo_0;
  logic        bo_1;
  logic        bo_2;
  logic        bo_3;
  logic [ADDR_W-1:0] li_ext;
  logic [ADDR_W-1:0] bd_ext;

  assign bo     = i_instr[25:21];
  assign bi     = i_instr[20:16];
  assign bh     = i_instr[12:11];
  assign xo     = i_instr[10:1];
  assign aa     = i_instr[1];
  assign lk     = i_instr[0];
  assign bo_0   = bo[4];
  assign bo_1   = bo[3];
  assign bo_2   = bo[2];
  assign bo_3   = bo[1];
  assign cr_idx = 5'd31 - bi;
  assign li_ext = {{(ADDR_W-26){i_instr[25]}}, i_instr[25:2], 2'b00};
  assign bd_ext = {{(ADDR_W-16){i_instr[15]}}, i_instr[15:2], 2'b00};

  // Opcode bits and the low TAR bits never influence the result
  logic unused_bits;
  assign unused_bits = ^{i_instr[31:26], i_target_address_register[1:0]};

  // Branch condition evaluation, always against pre-update CTR/LR
  logic [ADDR_W-1:0] seq_addr;
  logic [ADDR_W-1:0] ctr_m1;
  logic              ctr_nz;
  logic              ctr_ok;
  logic              cond_ok;
  logic              branch_active;

  assign seq_addr      = cia_reg + ADDR_FOUR;
  assign ctr_m1        = ctr_reg - ADDR_ONE;
  assign ctr_nz        = i_32b_mode ? (ctr_m1[31:0] != 32'd0) : (ctr_m1 != '0);
  assign ctr_ok        = bo_2 | (ctr_nz ^ bo_3);
  assign cond_ok       = bo_0 | (i_condition_register[cr_idx] == bo_1);
  // The boot cycle only replays CIA; a branch presented then is not executed
  assign branch_active = i_en & ~boot_reg;

  logic              legal;
  logic              taken;
  logic              dec_ctr;
  logic              is_bclr;
  logic [ADDR_W-1:0] target;

  // Decode the form/XO, decide legality, taken and the branch target
  always_comb begin
    legal   = 1'b0;
    taken   = 1'b0;
    dec_ctr = 1'b0;
    is_bclr = 1'b0;
    target  = seq_addr;
    if (branch_active) begin
      case (i_form)
        FORM_I: begin
          legal  = 1'b1;
          taken  = 1'b1;
          target = aa ? li_ext : cia_reg + li_ext;
        end
        FORM_B: begin
          legal   = 1'b1;
          dec_ctr = ~bo_2;
          taken   = ctr_ok & cond_ok;
          target  = aa ? bd_ext : cia_reg + bd_ext;
        end
        FORM_XL: begin
          case (xo)
            XO_BCLR: begin
              legal   = 1'b1;
              is_bclr = 1'b1;
              dec_ctr = ~bo_2;
              taken   = ctr_ok & cond_ok;
              target  = {lr_reg[ADDR_W-1:2], 2'b00};
            end
            XO_BCCTR: begin
              // Decrementing CTR while branching through it is undefined
              legal  = bo_2;
              taken  = bo_2 & cond_ok;
              target = {ctr_reg[ADDR_W-1:2], 2'b00};
            end
            XO_BCTAR: begin
              legal   = 1'b1;
              dec_ctr = ~bo_2;
              taken   = ctr_ok & cond_ok;
              target  = {i_target_address_register[ADDR_W-1:2], 2'b00};
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  logic [ADDR_W-1:0] nia_raw;
  logic [ADDR_W-1:0] nia;

  assign nia_raw = boot_reg ? cia_reg : (taken ? target : seq_addr);
  assign nia     = i_32b_mode ? {{(ADDR_W-32){1'b0}}, nia_raw[31:0]} : nia_raw;

  // RAS control: a link pushes the return address, a taken bclr with BH=00 pops
  logic push;
  logic pop_req;
  logic ras_nonempty;

  assign push         = legal & lk;
  assign pop_req      = taken & is_bclr & (bh == 2'b00);
  assign ras_nonempty = (ras_cnt_reg != '0);
  assign ras_top      = ras_mem[ras_ptr_reg];

  // Next RAS pointer/count and write port; bclrl swaps the top entry in place
  always_comb begin
    ras_we       = 1'b0;
    ras_waddr    = ras_ptr_reg;
    ras_ptr_next = ras_ptr_reg;
    ras_cnt_next = ras_cnt_reg;
    if (push && pop_req && ras_nonempty) begin
      ras_we    = 1'b1;
      ras_waddr = ras_ptr_reg;
    end else if (push) begin
      ras_we       = 1'b1;
      ras_waddr    = ras_ptr_reg + PTR_ONE;
      ras_ptr_next = ras_ptr_reg + PTR_ONE;
      if (ras_cnt_reg != CNT_FULL) begin
        ras_cnt_next = ras_cnt_reg + CNT_ONE;
      end
    end else if (pop_req && ras_nonempty) begin
      ras_ptr_next = ras_ptr_reg - PTR_ONE;
      ras_cnt_next = ras_cnt_reg - CNT_ONE;
    end
  end

  logic err_next;
  logic mispredict_next;
  logic spr_wr_req;

  assign spr_wr_req      = i_ctr_wr_en | i_lr_wr_en;
  assign err_next        = i_en & (i_stall | (branch_active & ~legal) | spr_wr_req);
  assign mispredict_next = ~i_stall & pop_req & ras_nonempty & (ras_top != target);

  // Architectural register and RAS pointer updates, frozen while stalled
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cia_reg        <= RESET_ADDR;
      ctr_reg        <= '0;
      lr_reg         <= '0;
      boot_reg       <= 1'b1;
      err_reg        <= 1'b0;
      mispredict_reg <= 1'b0;
      ras_ptr_reg    <= '0;
      ras_cnt_reg    <= '0;
    end else begin
      err_reg        <= err_next;
      mispredict_reg <= mispredict_next;
      if (!i_stall) begin
        cia_reg  <= nia;
        boot_reg <= 1'b0;
        if (dec_ctr) begin
          ctr_reg <= ctr_m1;
        end else if (!i_en && i_ctr_wr_en) begin
          ctr_reg <= i_ctr_wr_data;
        end
        if (push) begin
          lr_reg <= seq_addr;
        end else if (!i_en && i_lr_wr_en) begin
          lr_reg <= i_lr_wr_data;
        end
        ras_ptr_reg <= ras_ptr_next;
        ras_cnt_reg <= ras_cnt_next;
      end
    end
  end

  // RAS storage; entries beyond the valid count are never consulted
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_stall && ras_we) begin
      ras_mem[ras_waddr] <= seq_addr;
    end
  end

  assign o_next_instr_addr    = nia;
  assign o_current_instr_addr = cia_reg;
  assign o_count_register     = ctr_reg;
  assign o_link_register      = lr_reg;
  assign o_taken              = taken;
  assign o_ras_mispredict     = mispredict_reg;
  assign o_err                = err_reg;

endmodule

// File: tb/tb_branch_facility_xl.sv
// Directed testbench for branch_facility_xl with hand-computed expectations.
module tb_branch_facility_xl;

  localparam int ADDR_W = 64;

  logic              i_clk;
  logic              i_rst;
  logic              i_32b_mode;
  logic              i_stall;
  logic              i_en;
  logic [31:0]       i_instr;
  logic [1:0]        i_form;
  logic [31:0]       i_condition_register;
  logic [ADDR_W-1:0] i_target_address_register;
  logic              i_ctr_wr_en;
  logic [ADDR_W-1:0] i_ctr_wr_data;
  logic              i_lr_wr_en;
  logic [ADDR_W-1:0] i_lr_wr_data;
  logic [ADDR_W-1:0] o_next_instr_addr;
  logic [ADDR_W-1:0] o_current_instr_addr;
  logic [ADDR_W-1:0] o_count_register;
  logic [ADDR_W-1:0] o_link_register;
  logic              o_taken;
  logic              o_ras_mispredict;
  logic              o_err;

  int n_checks = 0;
  int n_errors = 0;

  branch_facility_xl #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (8),
    .RESET_ADDR(64'h0)
  ) dut (
    .i_clk                    (i_clk),
    .i_rst                    (i_rst),
    .i_32b_mode               (i_32b_mode),
    .i_stall                  (i_stall),
    .i_en                     (i_en),
    .i_instr                  (i_instr),
    .i_form                   (i_form),
    .i_condition_register     (i_condition_register),
    .i_target_address_register(i_target_address_register),
    .i_ctr_wr_en              (i_ctr_wr_en),
    .i_ctr_wr_data            (i_ctr_wr_data),
    .i_lr_wr_en               (i_lr_wr_en),
    .i_lr_wr_data             (i_lr_wr_data),
    .o_next_instr_addr        (o_next_instr_addr),
    .o_current_instr_addr     (o_current_instr_addr),
    .o_count_register         (o_count_register),
    .o_link_register          (o_link_register),
    .o_taken                  (o_taken),
    .o_ras_mispredict         (o_ras_mispredict),
    .o_err                    (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [1:0] F_I  = 2'b00;
  localparam logic [1:0] F_B  = 2'b01;
  localparam logic [1:0] F_XL = 2'b10;

  function automatic logic [31:0] mk_i(input logic [23:0] li, input logic aa, input logic lk);
    return {6'd18, li, aa, lk};
  endfunction

  function automatic logic [31:0] mk_b(input logic [4:0] bo, input logic [4:0] bi,
                                       input logic [13:0] bd, input logic aa, input logic lk);
    return {6'd16, bo, bi, bd, aa, lk};
  endfunction

  function automatic logic [31:0] mk_xl(input logic [4:0] bo, input logic [4:0] bi,
                                        input logic [1:0] bh, input logic [9:0] xo, input logic lk);
    return {6'd19, bo, bi, 3'b000, bh, xo, lk};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present a branch and stop mid-cycle so combinational outputs can be checked
  task automatic issue(input logic [1:0] form, input logic [31:0] instr);
    i_en    = 1'b1;
    i_form  = form;
    i_instr = instr;
    @(negedge i_clk);
    $display("txn form=%0d instr=%h cia=%h nia=%h taken=%0d",
             form, instr, o_current_instr_addr, o_next_instr_addr, o_taken);
  endtask

  // Close the current cycle and return all request inputs to idle
  task automatic retire();
    @(posedge i_clk);
    #1;
    i_en        = 1'b0;
    i_form      = 2'b00;
    i_instr     = 32'h0;
    i_stall     = 1'b0;
    i_ctr_wr_en = 1'b0;
    i_lr_wr_en  = 1'b0;
  endtask

  task automatic mtlr(input logic [63:0] v);
    i_lr_wr_en   = 1'b1;
    i_lr_wr_data = v;
    $display("txn mtlr %h", v);
    retire();
  endtask

  task automatic mtctr(input logic [63:0] v);
    i_ctr_wr_en   = 1'b1;
    i_ctr_wr_data = v;
    $display("txn mtctr %h", v);
    retire();
  endtask

  logic [31:0] blr;
  logic [31:0] bdnz;

  initial begin
    i_rst = 1'b1;
    i_32b_mode = 1'b0;
    i_stall = 1'b0;
    i_en = 1'b0;
    i_instr = 32'h0;
    i_form = 2'b00;
    i_condition_register = 32'h0;
    i_target_address_register = '0;
    i_ctr_wr_en = 1'b0;
    i_ctr_wr_data = '0;
    i_lr_wr_en = 1'b0;
    i_lr_wr_data = '0;
    blr  = mk_xl(5'b10100, 5'd0, 2'b00, 10'd16, 1'b0);
    bdnz = mk_b(5'b10000, 5'd0, 14'h0010, 1'b0, 1'b0);

    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    // Reset state and boot cycle
    chk("rst_cia", o_current_instr_addr, 64'h0);
    chk("rst_ctr", o_count_register, 64'h0);
    chk("rst_lr", o_link_register, 64'h0);
    chk("rst_err", {63'h0, o_err}, 64'h0);
    chk("rst_mis", {63'h0, o_ras_mispredict}, 64'h0);
    @(negedge i_clk);
    chk("boot_nia", o_next_instr_addr, 64'h0);
    retire();
    chk("cia_1", o_current_instr_addr, 64'h0);
    @(negedge i_clk);
    chk("seq_nia", o_next_instr_addr, 64'h4);
    retire();
    chk("cia_2", o_current_instr_addr, 64'h4);
    retire();
    chk("cia_3", o_current_instr_addr, 64'h8);

    // I-form: absolute jump to 0x100, then relative bl by -4
    issue(F_I, mk_i(24'h000040, 1'b1, 1'b0));
    chk("ba_nia", o_next_instr_addr, 64'h100);
    retire();
    chk("ba_cia", o_current_instr_addr, 64'h100);
    issue(F_I, mk_i(24'hFFFFFF, 1'b0, 1'b1));
    chk("bl_neg_nia", o_next_instr_addr, 64'hFC);
    chk("bl_neg_taken", {63'h0, o_taken}, 64'h1);
    retire();
    chk("bl_neg_lr", o_link_register, 64'h104);

    // bdnz: CTR=1 falls through, CTR=2 branches, CTR=0 wraps to all ones
    mtctr(64'h1);
    issue(F_B, bdnz);
    chk("bdnz1_taken", {63'h0, o_taken}, 64'h0);
    chk("bdnz1_nia", o_next_instr_addr, 64'h104);
    retire();
    chk("bdnz1_ctr", o_count_register, 64'h0);
    mtctr(64'h2);
    issue(F_B, bdnz);
    chk("bdnz2_taken", {63'h0, o_taken}, 64'h1);
    chk("bdnz2_nia", o_next_instr_addr, 64'h148);
    retire();
    chk("bdnz2_ctr", o_count_register, 64'h1);
    mtctr(64'h0);
    issue(F_B, bdnz);
    chk("bdnz0_nia", o_next_instr_addr, 64'h18C);
    retire();
    chk("bdnz0_ctr", o_count_register, 64'hFFFF_FFFF_FFFF_FFFF);

    // Call/return through the RAS, then a return with a corrupted LR
    issue(F_I, mk_i(24'h000080, 1'b1, 1'b0));
    retire();
    chk("to200_cia", o_current_instr_addr, 64'h200);
    issue(F_I, mk_i(24'h000040, 1'b0, 1'b1));
    chk("bl200_nia", o_next_instr_addr, 64'h300);
    retire();
    chk("bl200_lr", o_link_register, 64'h204);
    repeat (4) retire();
    chk("nops_cia", o_current_instr_addr, 64'h310);
    issue(F_XL, blr);
    chk("blr_taken", {63'h0, o_taken}, 64'h1);
    chk("blr_nia", o_next_instr_addr, 64'h204);
    retire();
    chk("blr_mis", {63'h0, o_ras_mispredict}, 64'h0);
    issue(F_I, mk_i(24'h000040, 1'b0, 1'b1));
    retire();
    mtlr(64'h300);
    issue(F_XL, blr);
    chk("blr_bad_nia", o_next_instr_addr, 64'h300);
    retire();
    chk("blr_bad_mis", {63'h0, o_ras_mispredict}, 64'h1);
    retire();
    chk("mis_pulse_end", {63'h0, o_ras_mispredict}, 64'h0);

    // Nine nested calls overflow the 8-deep RAS; nine returns follow
    issue(F_I, mk_i(24'h000400, 1'b1, 1'b0));
    retire();
    for (int k = 0; k < 9; k++) begin
      issue(F_I, mk_i(24'h000040, 1'b0, 1'b1));
      chk("nest_bl_nia", o_next_instr_addr, 64'h1100 + 64'(k) * 64'h100);
      retire();
    end
    for (int j = 8; j >= 0; j--) begin
      mtlr(64'h1004 + 64'(j) * 64'h100);
      issue(F_XL, blr);
      chk("nest_blr_nia", o_next_instr_addr, 64'h1004 + 64'(j) * 64'h100);
      retire();
      chk("nest_blr_mis", {63'h0, o_ras_mispredict}, 64'h0);
    end

    // 32-bit mode: upper address bits cleared, CTR zero test on low word
    i_32b_mode = 1'b1;
    issue(F_I, mk_i(24'hFFFFFF, 1'b1, 1'b0));
    chk("m32_ba_nia", o_next_instr_addr, 64'h0000_0000_FFFF_FFFC);
    retire();
    @(negedge i_clk);
    chk("m32_wrap_nia", o_next_instr_addr, 64'h0);
    retire();
    issue(F_XL, mk_xl(5'b00000, 5'd0, 2'b00, 10'd528, 1'b0));
    chk("bcctr_bad_taken", {63'h0, o_taken}, 64'h0);
    chk("bcctr_bad_nia", o_next_instr_addr, 64'h4);
    retire();
    chk("bcctr_bad_err", {63'h0, o_err}, 64'h1);
    chk("bcctr_bad_ctr", o_count_register, 64'hFFFF_FFFF_FFFF_FFFF);
    mtctr(64'h1_0000_0001);
    chk("err_pulse_end", {63'h0, o_err}, 64'h0);
    issue(F_B, bdnz);
    chk("m32_bdnz_taken", {63'h0, o_taken}, 64'h0);
    chk("m32_bdnz_nia", o_next_instr_addr, 64'hC);
    retire();
    chk("m32_bdnz_ctr", o_count_register, 64'h1_0000_0000);
    i_32b_mode = 1'b0;

    // Branch while stalled, SPR write conflict, illegal form and XO
    i_stall = 1'b1;
    issue(F_I, mk_i(24'h000140, 1'b1, 1'b0));
    retire();
    chk("stall_cia", o_current_instr_addr, 64'hC);
    chk("stall_err", {63'h0, o_err}, 64'h1);
    retire();
    chk("post_stall_cia", o_current_instr_addr, 64'h10);
    i_lr_wr_en   = 1'b1;
    i_lr_wr_data = 64'hDEAD;
    issue(F_I, mk_i(24'h000002, 1'b0, 1'b0));
    chk("conf_nia", o_next_instr_addr, 64'h18);
    retire();
    chk("conf_err", {63'h0, o_err}, 64'h1);
    chk("conf_lr", o_link_register, 64'h1004);
    issue(2'b11, 32'h0);
    chk("ill_form_taken", {63'h0, o_taken}, 64'h0);
    chk("ill_form_nia", o_next_instr_addr, 64'h1C);
    retire();
    chk("ill_form_err", {63'h0, o_err}, 64'h1);
    issue(F_XL, mk_xl(5'b10100, 5'd0, 2'b00, 10'd17, 1'b1));
    chk("ill_xo_taken", {63'h0, o_taken}, 64'h0);
    retire();
    chk("ill_xo_err", {63'h0, o_err}, 64'h1);
    chk("ill_xo_lr", o_link_register, 64'h1004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
